// File: rtl/gf_pkg.sv
// +----------------------------------------------------------------------------+
// | gf_pkg : GF(2^8) field constants, RS generator polynomial and multiplier  |
// | Rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

package gf_pkg;

    localparam int SYMB_WIDTH = 8;
    localparam int T_VAL      = 8;
    localparam int ROOTS_NUM  = 2 * T_VAL;
    localparam int FCR        = 0;
    localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11D;

    typedef logic [SYMB_WIDTH-1:0]                 symb_t;
    typedef logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0]  gen_poly_t;

    typedef enum logic [0:0] {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } enc_state_t;

    function automatic symb_t gf_mult(input symb_t a, input symb_t b);
        symb_t acc;
        symb_t aa;
        acc = '0;
        aa  = a;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = aa[SYMB_WIDTH-1] ? ((aa << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0]) : (aa << 1);
        end
        return acc;
    endfunction

    // g(x) = prod (x + alpha^(FCR+i)); the monic top coefficient is implicit.
    function automatic gen_poly_t calc_gen_poly();
        logic [ROOTS_NUM:0][SYMB_WIDTH-1:0] g;
        symb_t root;
        g    = '0;
        g[0] = symb_t'(1);
        root = symb_t'(1);
        for (int i = 0; i < FCR; i++) root = gf_mult(root, symb_t'(2));
        for (int i = 0; i < ROOTS_NUM; i++) begin
            for (int j = ROOTS_NUM; j > 0; j--) g[j] = g[j-1] ^ gf_mult(g[j], root);
            g[0] = gf_mult(g[0], root);
            root = gf_mult(root, symb_t'(2));
        end
        return g[ROOTS_NUM-1:0];
    endfunction

    localparam gen_poly_t GEN_POLY = calc_gen_poly();

endpackage

`default_nettype wire

// File: rtl/rs_enc_lfsr.sv
// +----------------------------------------------------------------------------+
// | rs_enc_lfsr : RS parity register with generator feedback and shift-out    |
// | Rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module rs_enc_lfsr
    import gf_pkg::*;
(
    input  logic  aclk,
    input  logic  aresetn,
    input  logic  clear,
    input  logic  load,
    input  logic  shift,
    input  symb_t din,
    output symb_t par_top
);

    gen_poly_t r_par;
    gen_poly_t w_load_next;
    symb_t     w_fb;

    assign w_fb = din ^ r_par[ROOTS_NUM-1];

    generate
        for (genvar j = 0; j < ROOTS_NUM; j++) begin : g_tap
            if (j == 0) begin : g_low
                assign w_load_next[j] = gf_mult(w_fb, GEN_POLY[j]);
            end else begin : g_mid
                assign w_load_next[j] = r_par[j-1] ^ gf_mult(w_fb, GEN_POLY[j]);
            end
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_par <= '0;
        end else if (clear) begin
            r_par <= '0;
        end else if (load) begin
            r_par <= w_load_next;
        end else if (shift) begin
            r_par <= {r_par[ROOTS_NUM-2:0], symb_t'(0)};
        end
    end

    assign par_top = r_par[ROOTS_NUM-1];

endmodule

`default_nettype wire

// File: rtl/rs_enc.sv
// +----------------------------------------------------------------------------+
// | rs_enc : systematic Reed-Solomon encoder, message passthrough + parity    |
// | Rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module rs_enc
    import gf_pkg::*;
#(
    parameter int K_LEN = 239
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [SYMB_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [SYMB_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  frame_len_error
);

    localparam int CNT_W = $clog2(K_LEN);
    localparam int PAR_W = $clog2(ROOTS_NUM);

    enc_state_t       r_state;
    logic [CNT_W-1:0] r_msg_cnt;
    logic [PAR_W-1:0] r_par_cnt;

    logic  w_slot_free;
    logic  w_accept;
    logic  w_frame_end;
    logic  w_par_last;
    logic  w_par_shift;
    symb_t w_par_top;

    assign w_slot_free = ~m_tvalid | m_tready;
    assign s_tready    = aresetn & (r_state == ST_DATA) & w_slot_free;
    assign w_accept    = s_tvalid & s_tready;
    assign w_frame_end = s_tlast | (r_msg_cnt == CNT_W'(K_LEN - 1));
    assign w_par_last  = (r_par_cnt == PAR_W'(ROOTS_NUM - 1));
    assign w_par_shift = (r_state == ST_PARITY) & w_slot_free;

    rs_enc_lfsr u_lfsr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (w_par_shift & w_par_last),
        .load    (w_accept),
        .shift   (w_par_shift),
        .din     (s_tdata),
        .par_top (w_par_top)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state         <= ST_DATA;
            r_msg_cnt       <= '0;
            r_par_cnt       <= '0;
            m_tdata         <= '0;
            m_tvalid        <= 1'b0;
            m_tlast         <= 1'b0;
            frame_len_error <= 1'b0;
        end else begin
            frame_len_error <= 1'b0;
            case (r_state)
                ST_DATA: begin
                    if (w_accept) begin
                        m_tdata  <= s_tdata;
                        m_tvalid <= 1'b1;
                        m_tlast  <= 1'b0;
                        if (w_frame_end) begin
                            // Forced end: remaining input symbols open a new frame.
                            r_state         <= ST_PARITY;
                            r_par_cnt       <= '0;
                            r_msg_cnt       <= '0;
                            frame_len_error <= ~s_tlast;
                        end else begin
                            r_msg_cnt <= r_msg_cnt + 1'b1;
                        end
                    end else if (m_tready) begin
                        m_tvalid <= 1'b0;
                        m_tlast  <= 1'b0;
                    end
                end
                ST_PARITY: begin
                    if (w_slot_free) begin
                        m_tdata   <= w_par_top;
                        m_tvalid  <= 1'b1;
                        m_tlast   <= w_par_last;
                        r_par_cnt <= r_par_cnt + 1'b1;
                        if (w_par_last) r_state <= ST_DATA;
                    end
                end
                default: r_state <= ST_DATA;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rs_enc.sv
// +----------------------------------------------------------------------------+
// | tb_rs_enc : randomized self-checking bench, polynomial-division model     |
// | Rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rs_enc;
    import gf_pkg::*;

    localparam int K_LEN = 239;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tlast;
    logic       m_tready;
    logic       frame_len_error;

    always #5 aclk = ~aclk;

    rs_enc #(.K_LEN(K_LEN)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .s_tlast         (s_tlast),
        .s_tready        (s_tready),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tlast         (m_tlast),
        .m_tready        (m_tready),
        .frame_len_error (frame_len_error)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Log/antilog GF(256) arithmetic, primitive polynomial x^8+x^4+x^3+x^2+1
    logic [7:0] gexp [0:254];
    int         glog [0:255];
    logic [7:0] gb   [0:ROOTS_NUM];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'd0 || b == 8'd0) return 8'd0;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    task automatic init_gf();
        logic [8:0] v;
        logic [7:0] r;
        v = 9'd1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = v[7:0];
            glog[v[7:0]] = i;
            v = v << 1;
            if (v[8]) v = v ^ 9'h11D;
        end
        for (int j = 0; j <= ROOTS_NUM; j++) gb[j] = 8'd0;
        gb[0] = 8'd1;
        for (int i = 0; i < ROOTS_NUM; i++) begin
            r = gexp[(FCR + i) % 255];
            for (int j = ROOTS_NUM; j > 0; j--) gb[j] = gb[j-1] ^ gmul(gb[j], r);
            gb[0] = gmul(gb[0], r);
        end
    endtask

    logic [8:0] in_q  [$];
    logic [8:0] exp_q [$];
    logic [7:0] cur_cw[$];
    int  beats      = 0;
    int  flerr_cnt  = 0;
    int  tready_pct = 100;
    int  valid_pct  = 100;
    bit  acc_now    = 1'b0;
    bit  prev_stall = 1'b0;
    logic [7:0] prev_data;

    // Expected codeword: message, then remainder of msg(x)*x^R divided by g(x).
    task automatic model_frame(input logic [7:0] msg[$]);
        int k;
        logic [7:0] p[];
        logic [7:0] c;
        k = msg.size();
        p = new[k + ROOTS_NUM];
        for (int i = 0; i < k + ROOTS_NUM; i++) p[i] = (i < k) ? msg[i] : 8'd0;
        for (int i = 0; i < k; i++) begin
            c = p[i];
            for (int j = 0; j <= ROOTS_NUM; j++) p[i+j] = p[i+j] ^ gmul(c, gb[ROOTS_NUM-j]);
        end
        for (int i = 0; i < k; i++) exp_q.push_back({1'b0, msg[i]});
        for (int i = 0; i < ROOTS_NUM; i++) exp_q.push_back({(i == ROOTS_NUM-1), p[k+i]});
    endtask

    task automatic queue_frame(input logic [7:0] msg[$]);
        for (int i = 0; i < msg.size(); i++) in_q.push_back({(i == msg.size()-1), msg[i]});
        model_frame(msg);
    endtask

    task automatic queue_random(input int k);
        logic [7:0] msg[$];
        for (int i = 0; i < k; i++) msg.push_back(8'($urandom));
        queue_frame(msg);
    endtask

    task automatic check_syndromes();
        logic [7:0] acc;
        logic [7:0] s;
        logic [7:0] r;
        acc = 8'd0;
        for (int i = 0; i < ROOTS_NUM; i++) begin
            r = gexp[(FCR + i) % 255];
            s = 8'd0;
            foreach (cur_cw[n]) s = gmul(s, r) ^ cur_cw[n];
            acc = acc | s;
        end
        check("syndrome", acc, 0);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
            @(posedge aclk);
            n++;
        end
        if (in_q.size() != 0 || exp_q.size() != 0) begin
            check("drain_timeout", in_q.size() + exp_q.size(), 0);
            in_q.delete();
            exp_q.delete();
        end
        repeat (3) @(posedge aclk);
    endtask

    // Output monitor and stall-stability checks
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_stall = 1'b0;
                acc_now    = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", m_tvalid, 1);
                    check("stall_data", m_tdata, prev_data);
                end
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
                if (frame_len_error) flerr_cnt++;
                acc_now = s_tvalid && s_tready;
                if (m_tvalid && m_tready) begin
                    beats++;
                    cur_cw.push_back(m_tdata);
                    check("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("data", m_tdata, e[7:0]);
                        check("last", m_tlast, e[8]);
                    end
                    if (m_tlast) begin
                        check_syndromes();
                        cur_cw.delete();
                    end
                end
            end
        end
    end

    // Input driver
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (acc_now && in_q.size() > 0) void'(in_q.pop_front());
            acc_now  = 1'b0;
            m_tready = ($urandom_range(99) < tready_pct);
            if (aresetn && in_q.size() > 0 && $urandom_range(99) < valid_pct) begin
                s_tvalid = 1'b1;
                {s_tlast, s_tdata} = in_q[0];
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                s_tdata  = 8'($urandom);
            end
        end
    end

    initial begin
        logic [7:0] msg[$];
        int b0;
        int f0;
        int n;

        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 8'd0;
        m_tready = 1'b1;
        init_gf();

        repeat (3) @(negedge aclk);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_flerr", frame_len_error, 0);
        for (int j = 0; j < ROOTS_NUM; j++) check("gen_poly", GEN_POLY[j], gb[j]);
        aresetn = 1'b1;

        // All-zero full-length frame
        msg.delete();
        for (int i = 0; i < K_LEN; i++) msg.push_back(8'd0);
        queue_frame(msg);
        drain(2000);
        check("flerr_none", flerr_cnt, 0);

        // Single-symbol frame
        msg.delete();
        msg.push_back(8'h01);
        queue_frame(msg);
        drain(200);

        // Random frames, input gaps, free-running output
        valid_pct = 70;
        for (int f = 0; f < 40; f++) queue_random($urandom_range(K_LEN, 1));
        drain(30000);

        // Back-to-back frames under 30% output duty
        valid_pct  = 100;
        tready_pct = 30;
        for (int f = 0; f < 20; f++) queue_random($urandom_range(K_LEN, 1));
        drain(40000);
        tready_pct = 100;

        // Overlength: forced split at K_LEN, tail becomes its own frame
        f0 = flerr_cnt;
        msg.delete();
        for (int i = 0; i < K_LEN + 3; i++) msg.push_back(8'($urandom));
        for (int i = 0; i < K_LEN + 3; i++) in_q.push_back({(i == K_LEN + 2), msg[i]});
        model_frame(msg[0:K_LEN-1]);
        model_frame(msg[K_LEN:K_LEN+2]);
        drain(2000);
        check("flerr_once", flerr_cnt - f0, 1);

        // Reset while the fifth parity symbol is presented
        b0 = beats;
        queue_random(10);
        n = 0;
        while (beats < b0 + 15 && n < 500) begin
            @(negedge aclk);
            #2;
            n++;
        end
        check("reached_parity5", beats - b0, 15);
        aresetn = 1'b0;
        #1;
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_s_tready", s_tready, 0);
        check("midrst_m_tdata", m_tdata, 0);
        in_q.delete();
        exp_q.delete();
        cur_cw.delete();
        acc_now = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        msg.delete();
        msg.push_back(8'h01);
        queue_frame(msg);
        drain(200);
        check("flerr_total", flerr_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
